nfa_range_engine: RTL

Runtime-programmable, parametrised successor to the generated fixed-automaton monitors in the `RM/monitor*` clusters. It holds `N_STE` state-transition elements, each with `N_RNG` programmable symbol ranges, a programmable fan-in row, a start type and a report flag. It consumes a symbol stream under valid/ready and pushes non-empty report vectors, tagged with the symbol index, into an internal FIFO drained by a valid/ready report port. It sits between the trace symbol encoder and the monitor report collector, and replaces per-property regenerated RTL with configuration writes.

---
 rtl/nfa_range_engine_pkg.sv | 31 +++
 rtl/nfa_range_engine_if.sv | 46 ++++
 rtl/nfa_report_fifo.sv | 69 ++++++
 rtl/nfa_range_engine.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/nfa_range_engine_pkg.sv
// -----------------------------------------------------------------------------
// nfa_engine_pkg
// Shared types and width helpers for the programmable range NFA engine.
//   start_type_e : STE start behaviour (none / start-of-data / every symbol)
//   cfg_sel_e    : target of a configuration write (range / fan-in row / attr)
//   max_int      : larger of two integers (config data width)
//   sel_width    : select width for an N-way index, never less than one bit
// -----------------------------------------------------------------------------
package nfa_engine_pkg;

   typedef enum logic [1:0] {
      NONE          = 2'd0,
      START_OF_DATA = 2'd1,
      ALL_INPUT     = 2'd2
   } start_type_e;

   typedef enum logic [1:0] {
      RANGE = 2'd0,
      ROW   = 2'd1,
      ATTR  = 2'd2
   } cfg_sel_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nfa_range_engine_if.sv
// -----------------------------------------------------------------------------
// nfa_range_engine_if
// Bundles the symbol stream, flush, configuration port, report port and the
// debug active vector of nfa_range_engine.
//   master : environment side (offers symbols, writes config, takes reports)
//   slave  : engine side
// -----------------------------------------------------------------------------
interface nfa_range_engine_if
   import nfa_engine_pkg::*;
#(
   parameter int SYM_W = 8,
   parameter int N_STE = 16,
   parameter int N_RNG = 2,
   parameter int IDX_W = 16,
   parameter int CFG_W = max_int(2 * SYM_W, N_STE)
) ();

   localparam int STE_SEL_W = sel_width(N_STE);
   localparam int RNG_SEL_W = sel_width(N_RNG);

   logic                 sym_valid;
   logic [SYM_W-1:0]     sym;
   logic                 sym_ready;
   logic                 flush;
   logic                 cfg_we;
   logic [1:0]           cfg_sel;
   logic [STE_SEL_W-1:0] cfg_ste;
   logic [RNG_SEL_W-1:0] cfg_rng;
   logic [CFG_W-1:0]     cfg_wdata;
   logic                 rpt_valid;
   logic                 rpt_ready;
   logic [IDX_W-1:0]     rpt_idx;
   logic [N_STE-1:0]     rpt_vec;
   logic [N_STE-1:0]     active;

   modport master (
      output sym_valid, sym, flush, cfg_we, cfg_sel, cfg_ste, cfg_rng, cfg_wdata, rpt_ready,
      input  sym_ready, rpt_valid, rpt_idx, rpt_vec, active
   );

   modport slave (
      input  sym_valid, sym, flush, cfg_we, cfg_sel, cfg_ste, cfg_rng, cfg_wdata, rpt_ready,
      output sym_ready, rpt_valid, rpt_idx, rpt_vec, active
   );

endinterface

// File: rtl/nfa_report_fifo.sv
// -----------------------------------------------------------------------------
// nfa_report_fifo
// Synchronous FIFO holding report entries. Output data comes straight from the
// storage registers at the read pointer, so a push into an empty FIFO is
// visible on o_data in the next cycle (no bypass path).
//   clk, reset_n : clock, asynchronous active-low reset
//   i_push/i_data: write strobe and entry (ignored when full)
//   i_pop        : read strobe (ignored when empty)
//   o_data       : head entry
//   o_full/o_empty/o_count : occupancy status
// -----------------------------------------------------------------------------
module nfa_report_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == {CNT_W{1'b0}});
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= {DATA_W{1'b0}};
         end
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/nfa_range_engine.sv
// -----------------------------------------------------------------------------
// nfa_range_engine
// Runtime-programmable NFA of N_STE state-transition elements. Each STE owns
// N_RNG symbol ranges, a fan-in row, a start type and a report flag. Accepted
// symbols advance the active vector; non-empty report vectors are pushed with
// the symbol index into a report FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : symbol stream, flush, config port, report port, active
// -----------------------------------------------------------------------------
module nfa_range_engine
   import nfa_engine_pkg::*;
#(
   parameter int SYM_W  = 8,
   parameter int N_STE  = 16,
   parameter int N_RNG  = 2,
   parameter int FIFO_D = 4,
   parameter int IDX_W  = 16,
   parameter int CFG_W  = max_int(2 * SYM_W, N_STE)
) (
   input logic                clk,
   input logic                reset_n,
   nfa_range_engine_if.slave  bus
);

   localparam int STE_SEL_W = sel_width(N_STE);
   localparam int RNG_SEL_W = sel_width(N_RNG);
   localparam int RPT_W     = IDX_W + N_STE;
   localparam int CNT_W     = $clog2(FIFO_D) + 1;

   logic [N_STE-1:0] r_active;
   logic [IDX_W-1:0] r_idx;
   logic             r_sod_armed;

   logic [N_STE-1:0] w_next;
   logic [N_STE-1:0] w_rpt_mask;
   logic [N_STE-1:0] w_nxt_rpt;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic [RPT_W-1:0] w_push_data;
   logic [RPT_W-1:0] w_head;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;

   // Ready depends only on FIFO occupancy (and flush), never on sym_valid
   assign bus.sym_ready = (w_fifo_count < CNT_W'(FIFO_D)) && !bus.flush;
   assign w_accept      = bus.sym_valid && bus.sym_ready;
   assign w_nxt_rpt     = w_next & w_rpt_mask;
   assign w_push        = w_accept && (|w_nxt_rpt) && !w_fifo_full;
   assign w_push_data   = {r_idx, w_nxt_rpt};
   assign w_pop         = !w_fifo_empty && bus.rpt_ready;

   assign bus.rpt_valid = !w_fifo_empty;
   assign bus.rpt_idx   = w_head[RPT_W-1:N_STE];
   assign bus.rpt_vec   = w_head[N_STE-1:0];
   assign bus.active    = r_active;

   for (genvar gi = 0; gi < N_STE; gi++) begin : g_ste
      logic [SYM_W-1:0] r_lo [N_RNG];
      logic [SYM_W-1:0] r_hi [N_RNG];
      logic [N_STE-1:0] r_row;
      logic [1:0]       r_start;
      logic             r_report;
      logic             w_sel_ste;
      logic [N_RNG-1:0] w_rm;
      logic             w_start_en;

      assign w_sel_ste = bus.cfg_we && (bus.cfg_ste == STE_SEL_W'(gi));

      // Config registers; written at the edge, so a same-cycle symbol sees the old values
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int r = 0; r < N_RNG; r++) begin
               r_lo[r] <= {SYM_W{1'b1}};
               r_hi[r] <= {SYM_W{1'b0}};
            end
            r_row    <= {N_STE{1'b0}};
            r_start  <= NONE;
            r_report <= 1'b0;
         end else if (w_sel_ste) begin
            case (bus.cfg_sel)
               RANGE: begin
                  for (int r = 0; r < N_RNG; r++) begin
                     if (bus.cfg_rng == RNG_SEL_W'(r)) begin
                        r_lo[r] <= bus.cfg_wdata[SYM_W-1:0];
                        r_hi[r] <= bus.cfg_wdata[2*SYM_W-1:SYM_W];
                     end
                  end
               end
               ROW:     r_row <= bus.cfg_wdata[N_STE-1:0];
               ATTR: begin
                  r_start  <= bus.cfg_wdata[1:0];
                  r_report <= bus.cfg_wdata[2];
               end
               default: r_row <= r_row;
            endcase
         end
      end

      // lo > hi yields an empty range without special handling
      for (genvar gr = 0; gr < N_RNG; gr++) begin : g_rng
         assign w_rm[gr] = (bus.sym >= r_lo[gr]) && (bus.sym <= r_hi[gr]);
      end

      // Start type 3 is treated like NONE because it matches neither term
      assign w_start_en = (r_start == ALL_INPUT) ||
                          ((r_start == START_OF_DATA) && r_sod_armed);
      assign w_next[gi]     = (|w_rm) && ((|(r_active & r_row)) || w_start_en);
      assign w_rpt_mask[gi] = r_report;
   end

   // Engine state: flush beats accept; otherwise hold
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active    <= {N_STE{1'b0}};
         r_idx       <= {IDX_W{1'b0}};
         r_sod_armed <= 1'b1;
      end else if (bus.flush) begin
         r_active    <= {N_STE{1'b0}};
         r_idx       <= {IDX_W{1'b0}};
         r_sod_armed <= 1'b1;
      end else if (w_accept) begin
         r_active    <= w_next;
         r_idx       <= r_idx + IDX_W'(1);
         r_sod_armed <= 1'b0;
      end else begin
         r_active    <= r_active;
         r_idx       <= r_idx;
         r_sod_armed <= r_sod_armed;
      end
   end

   nfa_report_fifo #(
      .DEPTH  (FIFO_D),
      .DATA_W (RPT_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

endmodule
